instr_decode_stage: RTL and testbench

//  Pipelined, parametrised instruction decode stage for the multi-cycle processor.

---
 rtl/instr_decode_stage_pkg.sv | 29 ++
 rtl/instr_decode_stage_if.sv | 32 +++
 rtl/instr_decode_stage_fifo.sv | 43 ++++
 rtl/instr_decode_stage.sv | 80 ++++++++
 tb/tb_instr_decode_stage.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/instr_decode_stage_pkg.sv
// decode_pkg: default field widths, field positions, instruction classes and decoded-entry type.
package decode_pkg;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_OPC_W = 3;
  localparam int DEF_REG_W = 5;
  localparam int DEF_ADDR_W = 16;
  typedef enum logic [1:0] {
    CLS_ARITH = 2'd0,
    CLS_MEM   = 2'd1,
    CLS_CTRL  = 2'd2
  } cls_e;
  // Register specifiers sit directly below the opcode, MSB first.
  function automatic int reg_lsb(int instr_w, int opc_w, int reg_w, int idx);
    return instr_w - opc_w - (idx + 1) * reg_w;
  endfunction
  localparam int OPC_LSB = DEF_INSTR_W - DEF_OPC_W;
  localparam int REG0_LSB = reg_lsb(DEF_INSTR_W, DEF_OPC_W, DEF_REG_W, 0);
  localparam int REG1_LSB = reg_lsb(DEF_INSTR_W, DEF_OPC_W, DEF_REG_W, 1);
  localparam int REG2_LSB = reg_lsb(DEF_INSTR_W, DEF_OPC_W, DEF_REG_W, 2);
  typedef struct packed {
    logic [DEF_OPC_W-1:0]  opcode;
    logic [DEF_REG_W-1:0]  reg0;
    logic [DEF_REG_W-1:0]  reg1;
    logic [DEF_REG_W-1:0]  reg2;
    logic [DEF_ADDR_W-1:0] addr;
    cls_e                  cls;
    logic                  illegal;
  } dec_t;
endpackage

// File: rtl/instr_decode_stage_if.sv
// instr_decode_stage_if: raw instruction input handshake and decoded-entry output handshake.
interface instr_decode_stage_if
  import decode_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int OPC_W = DEF_OPC_W,
  parameter int REG_W = DEF_REG_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [OPC_W-1:0]   out_opcode;
  logic [REG_W-1:0]   out_reg0;
  logic [REG_W-1:0]   out_reg1;
  logic [REG_W-1:0]   out_reg2;
  logic [ADDR_W-1:0]  out_addr;
  cls_e               out_class;
  logic               out_illegal;
  modport master(
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_opcode, out_reg0, out_reg1, out_reg2, out_addr, out_class,
           out_illegal
  );
  modport slave(
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_opcode, out_reg0, out_reg1, out_reg2, out_addr, out_class,
           out_illegal
  );
endinterface

// File: rtl/instr_decode_stage_fifo.sv
// decode_fifo: DEPTH-entry synchronous FIFO with registered ready/valid and flush.
module decode_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         ready_q,
  output logic         valid_q
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;
  // Ready is the registered not-full flag, so a pop from a full buffer never frees a same-cycle slot.
  assign do_push = push && ready_q && !flush;
  assign do_pop = pop && valid_q && !flush;
  assign count_d = flush ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      if (do_push) mem_q[wptr_q] <= wdata;
      wptr_q <= flush ? '0 : wptr_q + AW'(do_push);
      rptr_q <= flush ? '0 : rptr_q + AW'(do_pop);
      count_q <= count_d;
      ready_q <= count_d < (AW+1)'(DEPTH);
      valid_q <= count_d != '0;
    end
  end
  assign rdata = mem_q[rptr_q];
endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: splits instruction words into fields, classifies them and buffers the result.
// Optional DECODE_STATS_EN adds saturating pop/illegal counters.
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int OPC_W = DEF_OPC_W,
  parameter int REG_W = DEF_REG_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  instr_decode_stage_if.slave  bus
`ifdef DECODE_STATS_EN
  ,
  output logic [31:0]          stat_total,
  output logic [31:0]          stat_illegal
`endif
);
  localparam int R0 = reg_lsb(INSTR_W, OPC_W, REG_W, 0);
  localparam int R1 = reg_lsb(INSTR_W, OPC_W, REG_W, 1);
  localparam int R2 = reg_lsb(INSTR_W, OPC_W, REG_W, 2);
  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_W-1:0]  reg0;
    logic [REG_W-1:0]  reg1;
    logic [REG_W-1:0]  reg2;
    logic [ADDR_W-1:0] addr;
    cls_e              cls;
    logic              illegal;
  } entry_t;
  entry_t           dec, head;
  logic [OPC_W-1:0] opc;
  assign opc = bus.in_instr[INSTR_W-1 -: OPC_W];
  always_comb begin
    dec.opcode = opc;
    dec.reg0 = bus.in_instr[R0 +: REG_W];
    dec.reg1 = bus.in_instr[R1 +: REG_W];
    dec.reg2 = bus.in_instr[R2 +: REG_W];
    dec.addr = bus.in_instr[ADDR_W-1:0];
    dec.cls = opc[OPC_W-1] ? (opc[OPC_W-2] ? CLS_CTRL : CLS_MEM) : CLS_ARITH;
    dec.illegal = &opc;
  end
  decode_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .push    (bus.in_valid),
    .pop     (bus.out_ready),
    .wdata   (dec),
    .rdata   (head),
    .ready_q (bus.in_ready),
    .valid_q (bus.out_valid)
  );
  assign bus.out_opcode = head.opcode;
  assign bus.out_reg0 = head.reg0;
  assign bus.out_reg1 = head.reg1;
  assign bus.out_reg2 = head.reg2;
  assign bus.out_addr = head.addr;
  assign bus.out_class = head.cls;
  assign bus.out_illegal = head.illegal;
`ifdef DECODE_STATS_EN
  logic        pop;
  logic [31:0] total_q, total_d, illegal_q, illegal_d;
  assign pop = bus.out_valid && bus.out_ready && !flush;
  always_comb begin
    total_d = total_q + 32'(pop && total_q != '1);
    illegal_d = illegal_q + 32'(pop && head.illegal && illegal_q != '1);
  end
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    total_q <= rst_n ? total_d : '0;
    illegal_q <= rst_n ? illegal_d : '0;
  end
  assign stat_total = total_q;
  assign stat_illegal = illegal_q;
`endif
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: directed checks of decode, buffering, backpressure, flush and reset.
module tb_instr_decode_stage;
  import decode_pkg::*;
  logic clk = 1'b0;
  logic rst_n, flush;
  int   n_checks = 0;
  int   n_errors = 0;
  instr_decode_stage_if b ();
`ifdef DECODE_STATS_EN
  logic [31:0] stat_total, stat_illegal;
`endif
  instr_decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (b)
`ifdef DECODE_STATS_EN
    ,
    .stat_total   (stat_total),
    .stat_illegal (stat_illegal)
`endif
  );
  always #5 clk = ~clk;
  localparam logic [31:0] W0 = 32'h2A30C123;
  localparam logic [31:0] W1 = 32'h40000001;
  localparam logic [31:0] W2 = 32'h80000002;
  localparam logic [31:0] W3 = 32'hC0000003;
  localparam logic [31:0] W4 = 32'hE0000004;
  localparam logic [31:0] W5 = 32'hC0000005;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] w);
    b.in_valid = 1'b1;
    b.in_instr = w;
    tick();
    b.in_valid = 1'b0;
  endtask
  initial begin
    logic [31:0] seq [5];
    seq = '{W1, W4, W2, W4, W5};
    rst_n = 1'b0;
    flush = 1'b0;
    b.in_valid = 1'b0;
    b.in_instr = '0;
    b.out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_valid", 32'(b.out_valid), 0);
    check("rst_ready", 32'(b.in_ready), 1);
    check("rst_fields", {b.out_opcode, b.out_reg0, b.out_reg1, b.out_reg2, b.out_addr}, 0);
    check("rst_cls_ill", {b.out_class, b.out_illegal}, 0);
`ifdef DECODE_STATS_EN
    check("rst_stat_total", stat_total, 0);
    check("rst_stat_illegal", stat_illegal, 0);
`endif
    push(W0);
    check("t1_valid", 32'(b.out_valid), 1);
    check("t1_opcode", 32'(b.out_opcode), 1);
    check("t1_class", 32'(b.out_class), CLS_ARITH);
    check("t1_reg0", 32'(b.out_reg0), 32'h0A);
    check("t1_reg1", 32'(b.out_reg1), 32'h06);
    check("t1_reg2", 32'(b.out_reg2), 32'h03);
    check("t1_addr", 32'(b.out_addr), 32'hC123);
    check("t1_illegal", 32'(b.out_illegal), 0);
    b.out_ready = 1'b1;
    tick();
    b.out_ready = 1'b0;
    check("t1_drained", 32'(b.out_valid), 0);
    push(W1);
    check("t2_ready1", 32'(b.in_ready), 1);
    push(W2);
    check("t2_ready2", 32'(b.in_ready), 0);
    push(W3);
    check("t2_ready3", 32'(b.in_ready), 0);
    check("t2_hold_valid", 32'(b.out_valid), 1);
    check("t2_hold_addr", 32'(b.out_addr), 1);
    check("t2_hold_class", 32'(b.out_class), CLS_ARITH);
    b.out_ready = 1'b1;
    tick();
    check("t2_pop1_addr", 32'(b.out_addr), 2);
    check("t2_pop1_class", 32'(b.out_class), CLS_MEM);
    check("t2_pop1_ready", 32'(b.in_ready), 1);
    tick();
    check("t2_empty", 32'(b.out_valid), 0);
    b.out_ready = 1'b0;
    push(W1);
    push(W2);
    check("t3_full", 32'(b.in_ready), 0);
    b.out_ready = 1'b1;
    push(W3);
    check("t3_refused_ready", 32'(b.in_ready), 1);
    check("t3_head_addr", 32'(b.out_addr), 2);
    push(W3);
    check("t3_accept_valid", 32'(b.out_valid), 1);
    check("t3_accept_addr", 32'(b.out_addr), 3);
    tick();
    check("t3_empty", 32'(b.out_valid), 0);
    b.out_ready = 1'b0;
    push(W4);
    push(W5);
    check("t4_ill_flag", 32'(b.out_illegal), 1);
    check("t4_ill_class", 32'(b.out_class), CLS_CTRL);
    check("t4_ill_opcode", 32'(b.out_opcode), 7);
    b.out_ready = 1'b1;
    tick();
    check("t4_ctrl_flag", 32'(b.out_illegal), 0);
    check("t4_ctrl_class", 32'(b.out_class), CLS_CTRL);
    check("t4_ctrl_addr", 32'(b.out_addr), 5);
    tick();
    b.out_ready = 1'b0;
    push(W1);
    push(W2);
    flush = 1'b1;
    push(W3);
    flush = 1'b0;
    check("t5_valid", 32'(b.out_valid), 0);
    check("t5_ready", 32'(b.in_ready), 1);
    tick();
    check("t5_lost", 32'(b.out_valid), 0);
    push(W5);
    check("t5_after_valid", 32'(b.out_valid), 1);
    check("t5_after_addr", 32'(b.out_addr), 5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_valid", 32'(b.out_valid), 0);
    check("midrst_ready", 32'(b.in_ready), 1);
    for (int i = 0; i < 5; i++) begin
      push(seq[i]);
      check("t6_opcode", 32'(b.out_opcode), 32'(seq[i][31:29]));
      b.out_ready = 1'b1;
      tick();
      b.out_ready = 1'b0;
    end
    check("t6_empty", 32'(b.out_valid), 0);
`ifdef DECODE_STATS_EN
    check("t6_total", stat_total, 5);
    check("t6_illegal", stat_illegal, 2);
`endif
    flush = 1'b1;
    tick();
    flush = 1'b0;
`ifdef DECODE_STATS_EN
    check("t6_flush_total", stat_total, 5);
    check("t6_flush_illegal", stat_illegal, 2);
`endif
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_rst_valid", 32'(b.out_valid), 0);
`ifdef DECODE_STATS_EN
    check("t6_rst_total", stat_total, 0);
    check("t6_rst_illegal", stat_illegal, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
